// File: rtl/clock_contention.sv
// -----------------------------------------------------------------------------
// clock_contention
//
// Clock-enable generator and CPU contention arbiter for the Spectrum core.
// A free-running DIVW-bit counter on the master clock produces:
//   * fixed pixel/peripheral enables (14 MHz, 7 MHz rising and falling),
//   * a raw CPU enable pair whose period is selectable (turbo),
//   * the CPU enable pair after contention, which suppresses raw CPU edges
//     while the CPU is about to touch contended memory or the ULA port
//     inside the video contention window.
//
// Parameters
//   DIVW    master-clock divider width, master = 2^DIVW x 3.5 MHz (>= 4)
//   TURBOW  width of the turbo select
//
// Ports
//   clock       in   master clock (56 MHz at DIVW=4)
//   reset       in   asynchronous active-low reset
//   mode        in   contention model: 0=48K 1=128K 2=+3 3=none
//   turbo       in   CPU rate select, period = 2^(DIVW-turbo) clocks
//   mreq        in   CPU memory request, active low
//   iorq        in   CPU I/O request, active low
//   a           in   CPU address
//   ramPage     in   RAM page mapped at C000h
//   vduC        in   video contention window (high = open)
//   pe14M       out  14 MHz enable
//   pe7M0       out  7 MHz pixel enable, rising
//   ne7M0       out  7 MHz pixel enable, falling
//   necpu       out  CPU falling-edge enable after contention
//   pecpu       out  CPU rising-edge enable after contention
//   stall       out  current raw CPU edge is being suppressed
//   stallCount  out  saturating count of suppressed raw pecpu edges
// -----------------------------------------------------------------------------
module clock_contention #(
    parameter int DIVW   = 4,
    parameter int TURBOW = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [TURBOW-1:0] turbo,
    input  logic              mreq,
    input  logic              iorq,
    input  logic [15:0]       a,
    input  logic [2:0]        ramPage,
    input  logic              vduC,
    output logic              pe14M,
    output logic              pe7M0,
    output logic              ne7M0,
    output logic              necpu,
    output logic              pecpu,
    output logic              stall,
    output logic [15:0]       stallCount
);

    // Highest usable turbo level: limited both by the select width and by
    // the divider (the fastest CPU period is two master clocks).
    localparam int TURBO_SEL_MAX = (2 ** TURBOW) - 1;
    localparam int TURBO_CAP     = (TURBO_SEL_MAX < DIVW - 1) ? TURBO_SEL_MAX : DIVW - 1;
    localparam logic [TURBOW-1:0] TURBO_MAX = TURBOW'(TURBO_CAP);

    localparam logic [1:0] MODE_48K  = 2'd0;
    localparam logic [1:0] MODE_128K = 2'd1;
    localparam logic [1:0] MODE_P3   = 2'd2;
    localparam logic [1:0] MODE_NONE = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DIVW-1:0]   cnt_reg;
    logic              pe14m_reg;
    logic              ne7m0_reg;
    logic              pe7m0_reg;
    logic              ne_raw_reg;
    logic              pe_raw_reg;
    logic [TURBOW-1:0] turbo_q_reg;
    logic [1:0]        mode_q_reg;
    logic              idle_reg;
    logic              phase_reg;
    logic [15:0]       stall_count_reg;

    // -------------------------------------------------------------------------
    // Per-turbo-level compare against the counter. Level gi has period
    // P = 2^(DIVW-gi), so only the low DIVW-gi counter bits matter:
    //   falling edge at cnt mod P == P/2-1, rising edge at cnt mod P == P-1.
    // Select codes above the cap never reach turbo_q_reg, their slots are 0.
    // -------------------------------------------------------------------------
    logic [2**TURBOW-1:0] ne_hit;
    logic [2**TURBOW-1:0] pe_hit;

    generate
        for (genvar gi = 0; gi < 2 ** TURBOW; gi++) begin : g_level
            if (gi <= TURBO_CAP) begin : g_used
                localparam int LW = DIVW - gi;
                localparam logic [LW-1:0] NE_AT = LW'((2 ** (LW - 1)) - 1);
                assign ne_hit[gi] = (cnt_reg[LW-1:0] == NE_AT);
                assign pe_hit[gi] = &cnt_reg[LW-1:0];
            end else begin : g_unused
                assign ne_hit[gi] = 1'b0;
                assign pe_hit[gi] = 1'b0;
            end
        end
    endgenerate

    // Clamp the requested rate to what the divider can deliver.
    logic [TURBOW-1:0] turbo_sel;
    assign turbo_sel = (turbo > TURBO_MAX) ? TURBO_MAX : turbo;

    // -------------------------------------------------------------------------
    // Contention decode (uses the rate/model latched at the last raw pecpu)
    // -------------------------------------------------------------------------
    logic ula_io;
    logic mem_cont;
    logic io_cont;
    logic en_c;
    logic stall_int;
    logic pecpu_int;
    logic necpu_int;

    assign ula_io = !iorq && !a[0];

    always_comb begin
        mem_cont = 1'b0;
        case (mode_q_reg)
            MODE_48K:  mem_cont = (a[15:14] == 2'b01);
            MODE_128K: mem_cont = (a[15:14] == 2'b01) || ((a[15:14] == 2'b11) && ramPage[0]);
            MODE_P3:   mem_cont = (a[15:14] == 2'b01) || ((a[15:14] == 2'b11) && ramPage[2]);
            MODE_NONE: mem_cont = 1'b0;
            default:   mem_cont = 1'b0;
        endcase
    end

    // Only the 48K and 128K ULAs contend the even I/O port.
    assign io_cont = ula_io && !mode_q_reg[1];

    // Contention only exists at the native 3.5 MHz rate.
    assign en_c = (turbo_q_reg == '0) && (mode_q_reg != MODE_NONE);

    // idle means the CPU was not mid-access at the last delivered rising edge,
    // so a new contended access is about to start; phase selects which 7 MHz
    // slots inside the window are blocked.
    assign stall_int = en_c && phase_reg && vduC && idle_reg && (mem_cont || io_cont);

    assign necpu_int = ne_raw_reg && !stall_int;
    assign pecpu_int = pe_raw_reg && !stall_int;

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg         <= '0;
            pe14m_reg       <= 1'b0;
            ne7m0_reg       <= 1'b0;
            pe7m0_reg       <= 1'b0;
            ne_raw_reg      <= 1'b0;
            pe_raw_reg      <= 1'b0;
            turbo_q_reg     <= '0;
            mode_q_reg      <= MODE_48K;
            idle_reg        <= 1'b1;
            phase_reg       <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIVW'(1);

            // Fixed enables: registered one clock after the counter compare.
            pe14m_reg <= (cnt_reg[1:0] == 2'd3);
            ne7m0_reg <= (cnt_reg[2:0] == 3'd3);
            pe7m0_reg <= (cnt_reg[2:0] == 3'd7);

            // Raw CPU edges at the currently latched rate.
            ne_raw_reg <= ne_hit[turbo_q_reg];
            pe_raw_reg <= pe_hit[turbo_q_reg];

            // Rate and model only change on a raw rising edge, so the new
            // period starts from a CPU cycle boundary.
            if (pe_raw_reg) begin
                turbo_q_reg <= turbo_sel;
                mode_q_reg  <= mode;
            end

            if (pecpu_int) begin
                idle_reg <= mreq && !ula_io;
            end

            // Toggle each 7 MHz step; hold at 1 while stalled so the stretch
            // lasts in whole 7 MHz steps until the window closes.
            if (pe7m0_reg) begin
                phase_reg <= !(phase_reg && !stall_int);
            end

            if (pe_raw_reg && stall_int && (stall_count_reg != 16'hFFFF)) begin
                stall_count_reg <= stall_count_reg + 16'd1;
            end
        end
    end

    // Address bits 13..1 and ramPage[1] do not take part in contention.
    logic unused_bits;
    assign unused_bits = ^{a[13:1], ramPage[1]};

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pe14M      = pe14m_reg;
    assign pe7M0      = pe7m0_reg;
    assign ne7M0      = ne7m0_reg;
    assign necpu      = necpu_int;
    assign pecpu      = pecpu_int;
    assign stall      = stall_int;
    assign stallCount = stall_count_reg;

endmodule
